// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: FSM encoding, default timeout and
// peripheral base addresses on the APB segment.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic [31:0] INTC_BASE = 32'h2000_0000;

endpackage

// File: rtl/apb_timeout.sv
// ACCESS-phase watchdog: counts stalled cycles and flags the last permitted one.
module apb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  assign expired = (count_r == LAST);

  // Counter saturates at the expiry value so it can never wrap.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (en && !expired) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB initiator bridging the CPU req/ack port onto APB;
// reports responder errors and timeouts to the CPU and as an apb_perr pulse.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  input  logic                  cpu_we,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  pready,
  input  logic                  perr,
  output logic                  apb_perr
);

  apb_state_e            state_r;
  apb_state_e            state_next;
  logic                  expired_s;
  logic                  psel_s;
  logic                  penable_s;
  logic                  ack_s;
  logic                  err_s;
  logic                  perr_pulse_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  start_s;

  assign start_s = (state_r == ST_IDLE) && cpu_req;

  apb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .pclk   (pclk),
    .presetn(presetn),
    .clr    (state_r == ST_SETUP),
    .en     ((state_r == ST_ACCESS) && !pready),
    .expired(expired_s)
  );

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic; pready has priority over a simultaneous timeout.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req) state_next = ST_SETUP;
        else         state_next = ST_IDLE;
      end
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (pready || expired_s) state_next = ST_RESP;
        else                     state_next = ST_ACCESS;
      end
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered APB/CPU outputs.
  always_comb begin
    err_s   = cpu_err;
    rdata_s = cpu_rdata;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req) err_s = 1'b0;
        else         err_s = cpu_err;
      end
      ST_ACCESS: begin
        if (pready) begin
          err_s = perr;
          if (!pwrite) rdata_s = prdata;
          else         rdata_s = cpu_rdata;
        end else if (expired_s) begin
          err_s = 1'b1;
        end else begin
          err_s = cpu_err;
        end
      end
      default: begin
        err_s   = cpu_err;
        rdata_s = cpu_rdata;
      end
    endcase
    psel_s       = (state_next == ST_SETUP) || (state_next == ST_ACCESS);
    penable_s    = (state_next == ST_ACCESS);
    ack_s        = (state_next == ST_RESP);
    perr_pulse_s = (state_next == ST_RESP) && err_s;
  end

  // Output registers; request fields are captured once and held for the transfer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      cpu_ack   <= 1'b0;
      apb_perr  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= {DATA_WIDTH{1'b0}};
      paddr     <= {ADDR_WIDTH{1'b0}};
      pdata     <= {DATA_WIDTH{1'b0}};
      pwrite    <= 1'b0;
      pstb      <= 4'b0000;
    end else begin
      psel      <= psel_s;
      penable   <= penable_s;
      cpu_ack   <= ack_s;
      apb_perr  <= perr_pulse_s;
      cpu_err   <= err_s;
      cpu_rdata <= rdata_s;
      if (start_s) begin
        paddr  <= cpu_addr;
        pwrite <= cpu_we;
        pstb   <= cpu_we ? cpu_wstrb : 4'b0000;
        if (cpu_we) pdata <= cpu_wdata;
        else        pdata <= pdata;
      end else begin
        paddr  <= paddr;
        pwrite <= pwrite;
        pstb   <= pstb;
        pdata  <= pdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small wait-state/error APB responder model.
module tb_apb_master;
  import apb_pkg::*;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_we;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic [31:0] prdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstb;
  logic        pready;
  logic        perr;
  logic        apb_perr;

  int passed = 0;
  int total  = 0;

  // responder model controls
  logic        tb_init;
  logic        resp_en;
  int          wait_cfg;
  logic        perr_cfg;
  int          acc_cnt;
  logic [31:0] mem [0:15];

  always #5 pclk = ~pclk;

  apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .presetn(presetn), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_we(cpu_we), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .paddr(paddr), .pdata(pdata),
    .prdata(prdata), .psel(psel), .penable(penable), .pwrite(pwrite), .pstb(pstb),
    .pready(pready), .perr(perr), .apb_perr(apb_perr)
  );

  assign pready = resp_en && psel && penable && (acc_cnt == wait_cfg);
  assign perr   = perr_cfg;
  assign prdata = mem[paddr[5:2]];

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (tb_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[2] <= 32'hA5A5_1234;
      mem[3] <= 32'hDEAD_BEEF;
    end else if (psel && penable && pready && pwrite) begin
      for (int b = 0; b < 4; b++)
        if (pstb[b]) mem[paddr[5:2]][8*b +: 8] <= pdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int lat, output logic [31:0] rd,
                      output logic er, output logic pe_ack, output logic after,
                      output int n_setup, output int n_access, output logic [3:0] stb,
                      output logic stable);
    lat = -1; rd = 32'h0; er = 1'b0; pe_ack = 1'b0; n_setup = 0; n_access = 0;
    stb = 4'h0; stable = 1'b1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge pclk); #1;
      if (psel && !penable) n_setup++;
      if (psel && penable) begin
        n_access++;
        stb = pstb;
        if (paddr !== a || pwrite !== we) stable = 1'b0;
      end
      if (cpu_ack) begin
        lat = i; rd = cpu_rdata; er = cpu_err; pe_ack = apb_perr;
        cpu_req = 1'b0;
      end
    end
    @(posedge pclk); #1;
    after = apb_perr | cpu_ack;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, ns, na, nack, nacks_rst;
    int          ack_cyc [0:1];
    logic [31:0] rd;
    logic [31:0] setup_addr [0:1];
    logic        er, pe, after, stable;
    logic [3:0]  stb;

    presetn = 1'b0; tb_init = 1'b1; resp_en = 1'b1; wait_cfg = 1; perr_cfg = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_ctrl", {28'h0, psel, penable, cpu_ack, apb_perr}, 32'h0);
    check("reset_err", {31'h0, cpu_err}, 32'h0);
    check("reset_rdata", cpu_rdata, 32'h0);
    check("reset_paddr", paddr, 32'h0);
    presetn = 1'b1; tb_init = 1'b0;
    @(posedge pclk); #1;
    check("idle_psel", {31'h0, psel}, 32'h0);

    // write to interrupt controller, registered pready
    xfer(1'b1, INTC_BASE + 32'h4, 32'h0000_0001, 4'hF, lat, rd, er, pe, after, ns, na, stb, stable);
    check("wr_latency", lat, 32'd4);
    check("wr_err", {31'h0, er}, 32'h0);
    check("wr_pstb", {28'h0, stb}, 32'hF);
    check("wr_setup_cycles", ns, 32'd1);
    check("wr_access_cycles", na, 32'd2);
    check("wr_stable", {31'h0, stable}, 32'h1);
    check("wr_single_ack", {31'h0, after}, 32'h0);

    xfer(1'b0, INTC_BASE + 32'h4, 32'h0, 4'h0, lat, rd, er, pe, after, ns, na, stb, stable);
    check("rd_back_latency", lat, 32'd4);
    check("rd_back_data", rd, 32'h0000_0001);
    check("rd_back_pstb", {28'h0, stb}, 32'h0);

    // three wait states: pready on the 4th ACCESS cycle beats the timeout
    wait_cfg = 3;
    xfer(1'b0, INTC_BASE + 32'h8, 32'h0, 4'hF, lat, rd, er, pe, after, ns, na, stb, stable);
    check("wait3_latency", lat, 32'd6);
    check("wait3_data", rd, 32'hA5A5_1234);
    check("wait3_err", {31'h0, er}, 32'h0);
    check("wait3_pstb", {28'h0, stb}, 32'h0);
    check("wait3_stable", {31'h0, stable}, 32'h1);
    check("wait3_access_cycles", na, 32'd4);

    // responder error
    wait_cfg = 0; perr_cfg = 1'b1;
    xfer(1'b0, INTC_BASE + 32'hC, 32'h0, 4'h0, lat, rd, er, pe, after, ns, na, stb, stable);
    check("perr_latency", lat, 32'd3);
    check("perr_err", {31'h0, er}, 32'h1);
    check("perr_pulse_at_ack", {31'h0, pe}, 32'h1);
    check("perr_pulse_single", {31'h0, after}, 32'h0);
    check("perr_rdata", rd, 32'hDEAD_BEEF);
    perr_cfg = 1'b0;

    // timeout: no pready at all
    resp_en = 1'b0;
    xfer(1'b0, INTC_BASE + 32'h4, 32'h0, 4'h0, lat, rd, er, pe, after, ns, na, stb, stable);
    check("tmo_access_cycles", na, 32'd4);
    check("tmo_latency", lat, 32'd6);
    check("tmo_err", {31'h0, er}, 32'h1);
    check("tmo_perr_pulse", {31'h0, pe}, 32'h1);
    check("tmo_rdata_kept", rd, 32'hDEAD_BEEF);
    check("tmo_single", {31'h0, after}, 32'h0);

    // reset in the middle of ACCESS
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = INTC_BASE + 32'h18; cpu_wdata = 32'h55; cpu_wstrb = 4'h3;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    check("rst_mid_in_access", {30'h0, psel, penable}, 32'h3);
    #2 presetn = 1'b0;
    #1;
    check("rst_mid_ctrl", {24'h0, psel, penable, pwrite, cpu_ack, cpu_err, apb_perr, 2'b00}, 32'h0);
    check("rst_mid_pstb", {28'h0, pstb}, 32'h0);
    check("rst_mid_paddr", paddr, 32'h0);
    check("rst_mid_pdata", pdata, 32'h0);
    cpu_req = 1'b0;
    nacks_rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      if (cpu_ack) nacks_rst++;
      if (i == 1) presetn = 1'b1;
    end
    check("rst_mid_no_ack", nacks_rst, 32'd0);
    resp_en = 1'b1; wait_cfg = 0;
    xfer(1'b0, INTC_BASE + 32'h4, 32'h0, 4'h0, lat, rd, er, pe, after, ns, na, stb, stable);
    check("post_rst_latency", lat, 32'd3);
    check("post_rst_data", rd, 32'h0000_0001);
    check("post_rst_err", {31'h0, er}, 32'h0);

    // back-to-back writes with cpu_req held high
    nack = 0; ns = 0;
    ack_cyc[0] = -1; ack_cyc[1] = -1;
    setup_addr[0] = 32'h0; setup_addr[1] = 32'h0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = INTC_BASE + 32'h10; cpu_wdata = 32'h11; cpu_wstrb = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      @(posedge pclk); #1;
      if (psel && !penable) begin
        if (ns < 2) setup_addr[ns] = paddr;
        ns++;
      end
      if (cpu_ack) begin
        if (nack < 2) ack_cyc[nack] = i;
        nack++;
        if (nack == 1) begin
          cpu_addr = INTC_BASE + 32'h14; cpu_wdata = 32'h22;
        end else begin
          cpu_req = 1'b0;
        end
      end
    end
    check("b2b_ack_count", nack, 32'd2);
    check("b2b_setup_count", ns, 32'd2);
    check("b2b_ack0_cycle", ack_cyc[0], 32'd3);
    check("b2b_ack1_cycle", ack_cyc[1], 32'd7);
    check("b2b_addr0", setup_addr[0], INTC_BASE + 32'h10);
    check("b2b_addr1", setup_addr[1], INTC_BASE + 32'h14);
    check("b2b_mem0", mem[4], 32'h11);
    check("b2b_mem1", mem[5], 32'h22);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB initiator that bridges the CPU's simple request/acknowledge load/store port onto the peripheral APB bus. It drives the SETUP/ACCESS phases toward all APB responders, including the interrupt controller at 0x2000_0000. It returns read data, write completion or error to the CPU. It also raises the `apb_perr` pulse that feeds the interrupt controller's non-maskable `APB_perr` input when a responder errors or a transfer times out.

## Interface
- `ADDR_WIDTH`, 32: address width, CPU side and APB side.
- `DATA_WIDTH`, 32: data width; `pstb` is always 4 bits (DATA_WIDTH fixed at 32 for byte strobes).
- `TIMEOUT_CYCLES`, 255: maximum ACCESS cycles without `pready` before abort; legal range ≥1.

- `pclk`  in  1  single clock for all logic.
- `presetn`  in  1  reset, asynchronous assert, active-low.
- `cpu_req`  in  1  request valid; held by the CPU until `cpu_ack`.
- `cpu_addr`  in  ADDR_WIDTH  byte address.
- `cpu_wdata`  in  DATA_WIDTH  write data.
- `cpu_wstrb`  in  4  byte-write strobes.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_WIDTH  read data, valid with `cpu_ack`; holds its value until the next ack.
- `cpu_err`  out  1  error flag, valid with `cpu_ack`.
- `paddr`  out  ADDR_WIDTH  APB address.
- `pdata`  out  DATA_WIDTH  APB write data.
- `prdata`  in  DATA_WIDTH  APB read data.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction.
- `pstb`  out  4  APB strobes.
- `pready`  in  1  responder ready.
- `perr`  in  1  responder error, sampled only when `pready` = 1.
- `apb_perr`  out  1  one-cycle error pulse to the interrupt controller.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - When `cpu_req` = 1, latch addr/wdata/wstrb/we into internal registers and go to SETUP.
  - The CPU may change its inputs after `cpu_ack`.
- SETUP: `psel` = 1, `penable` = 0; unconditionally go to ACCESS.
- ACCESS:
  - `psel` = 1, `penable` = 1.
  - On `pready` = 1: capture `prdata` (reads only) and `perr` into `cpu_err`, then go to RESP.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES−1 and `pready` = 0: set `cpu_err` = 1, leave `cpu_rdata` unchanged, go to RESP.
- RESP: `cpu_ack` = 1, `psel` = `penable` = 0; go to IDLE.
- `apb_perr` = 1 in the RESP cycle iff `cpu_err` = 1; it is a single pulse.
- `paddr`, `pwrite` and `pdata` are driven from the latched registers and are stable for the whole SETUP+ACCESS phase.
- `pstb` = latched wstrb for writes and 4'b0000 for reads.
- Reads leave `pdata` at its previous value.
- Timeout counter:
  - width is the ceiling of log2(TIMEOUT_CYCLES+1);
  - cleared on entry to ACCESS;
  - never wraps.
- There is only one outstanding transfer; no pipelining.

## Timing
- Reset (`presetn` = 0, immediate, asynchronous) forces:
  - state = IDLE;
  - all outputs 0: `psel`, `penable`, `pwrite`, `pstb`, `paddr`, `pdata`, `cpu_ack`, `cpu_rdata`, `cpu_err`, `apb_perr`;
  - timeout counter = 0.
- Reset mid-transfer abandons the transfer; no ack is issued.
- Latency from `cpu_req` sampled in IDLE (cycle 0):
  - SETUP in cycle 1, ACCESS in cycle 2;
  - with `pready` in cycle 2+k, `cpu_ack` in cycle 3+k.
  - Example: zero-wait responder → ack in cycle 3; registered-pready responder such as the interrupt controller → ack in cycle 4.
- Back-to-back: a request held high through the ack cycle is sampled as a new request in the following IDLE cycle. Throughput is one transfer per ≥4 cycles.
- Simultaneous `pready` = 1 and timeout expiry: `pready` wins; `cpu_err` = `perr`.
- With `cpu_req` = 0, `psel` stays 0.

## Structure
- Shared package `apb_pkg` holds:
  - the state encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3);
  - the default TIMEOUT_CYCLES;
  - peripheral base-address constants (interrupt controller 0x2000_0000).
- One sub-module, `apb_timeout`: a clear/enable counter with a `expired` output, parameterized by TIMEOUT_CYCLES.

## Test plan
- Write 0x0000_0001 to 0x2000_0004 with wstrb 4'hF against the interrupt controller:
  - SETUP then ACCESS observed, `pstb` = 4'hF, `cpu_ack` 4 cycles after the request, `cpu_err` = 0;
  - a subsequent read returns 0x0000_0001.
- Read with `pready` held low for 3 ACCESS cycles: `pstb` = 0, `paddr`/`pwrite` stable throughout, `cpu_ack` in cycle 6, `cpu_rdata` = `prdata` sampled on `pready`.
- Responder returns `pready` = 1 with `perr` = 1: `cpu_err` = 1 and a single-cycle `apb_perr` aligned with `cpu_ack`.
- No `pready` with TIMEOUT_CYCLES = 4: ACCESS lasts exactly 4 cycles, then `cpu_ack` with `cpu_err` = 1 and an `apb_perr` pulse; `pready` on the 4th cycle instead completes normally with `cpu_err` = 0.
- `presetn` pulsed low during ACCESS: outputs go 0 immediately, no `cpu_ack`, and the next request completes normally.
- Two back-to-back requests (`cpu_req` held high): two distinct APB transfers, two single-cycle acks 4 cycles apart (zero-wait responder), no duplicate transfer.
